// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared definitions for the HDLC store-and-forward frame buffer.
//   - wr_state_t : write-side FSM encodings (IDLE / FRAME / DROP)
//   - entry_t    : buffer entry layout, bit 9 sop, bit 8 eop, bits 7:0 data
//   - AW_DEFAULT : default buffer address width (depth = 2**AW bytes)
package hdlc_pkg;

    localparam int AW_DEFAULT = 8;
    localparam int ENTRY_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/hdlc_frame_buffer_if.sv
// hdlc_frame_buffer_if: byte streams and status of the frame buffer.
//   Input stream : in_valid, sop_in, eop_in, error_in, data_in   (deframer -> buffer)
//   Output stream: out_valid, out_sop, out_eop, out_data, out_ready (buffer <-> sink)
//   Status       : overflow pulse, frame_cnt, drop_cnt
//   master = upstream/downstream environment, slave = the buffer.
interface hdlc_frame_buffer_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             sop_in;
    logic             eop_in;
    logic             error_in;
    logic [7:0]       data_in;
    logic             out_ready;
    logic             out_valid;
    logic             out_sop;
    logic             out_eop;
    logic [7:0]       out_data;
    logic             overflow;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] drop_cnt;

    modport master (
        output in_valid, sop_in, eop_in, error_in, data_in, out_ready,
        input  out_valid, out_sop, out_eop, out_data, overflow, frame_cnt, drop_cnt
    );

    modport slave (
        input  in_valid, sop_in, eop_in, error_in, data_in, out_ready,
        output out_valid, out_sop, out_eop, out_data, overflow, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/hdlc_buf_ram.sv
// hdlc_buf_ram: 2**AW x 10-bit dual-port storage, one synchronous write port
// and one asynchronous read port. Kept separate so a technology RAM can be
// dropped in. Contents are not reset.
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write entry {sop,eop,data}
//   i_raddr  : read address
//   o_rdata  : read entry (combinational)
module hdlc_buf_ram
    import hdlc_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  entry_t        i_wdata,
    input  logic [AW-1:0] i_raddr,
    output entry_t        o_rdata
);
    entry_t r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/hdlc_frame_buffer.sv
// hdlc_frame_buffer: store-and-forward buffer behind the HDLC deframer.
// Frames are written as they arrive and become readable only at an error-free
// eop; errored, aborted (sop without eop) and overflowing frames are rewound.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : hdlc_frame_buffer_if.slave (input stream, output stream, status)
//
//   state | meaning
//   IDLE  | waiting for a sop byte; non-sop bytes are ignored
//   FRAME | writing the bytes of the current frame
//   DROP  | frame overflowed; discarding bytes until its eop
module hdlc_frame_buffer
    import hdlc_pkg::*;
#(
    parameter int AW    = AW_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    hdlc_frame_buffer_if.slave  bus
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    wr_state_t        r_state, w_state_nxt;
    logic [AW:0]      r_wr_ptr, r_frm_ptr, r_cmt_ptr, r_rd_ptr;
    logic [AW:0]      w_wr_nxt, w_frm_nxt, w_cmt_nxt;
    logic [AW:0]      w_base, w_fill;
    logic             w_full, w_start, w_we, w_overflow, w_frame_inc, w_load;
    logic [1:0]       w_drop_add;
    logic [CNT_W:0]   w_frame_sum, w_drop_sum;
    entry_t           w_wdata, w_rdata, r_out;
    logic             r_out_valid, r_overflow;
    logic [CNT_W-1:0] r_frame_cnt, r_drop_cnt;

    // A sop inside FRAME restarts at the rewound frame start, so fullness
    // must be judged from there rather than from the current write pointer.
    assign w_base  = (r_state == FRAME && bus.sop_in) ? r_frm_ptr : r_wr_ptr;
    assign w_fill  = w_base - r_rd_ptr;
    assign w_full  = (w_fill == DEPTH);
    assign w_wdata = '{sop: bus.sop_in, eop: bus.eop_in, data: bus.data_in};

    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr_ptr;
        w_frm_nxt   = r_frm_ptr;
        w_cmt_nxt   = r_cmt_ptr;
        w_start     = 1'b0;
        w_we        = 1'b0;
        w_overflow  = 1'b0;
        w_frame_inc = 1'b0;
        w_drop_add  = 2'd0;

        case (r_state)
            IDLE: begin
                if (bus.in_valid && bus.sop_in) w_start = 1'b1;
            end
            FRAME: begin
                if (bus.in_valid) begin
                    if (bus.sop_in) begin
                        w_drop_add = 2'd1;
                        w_start    = 1'b1;
                    end else if (w_full) begin
                        w_overflow  = 1'b1;
                        w_drop_add  = 2'd1;
                        w_wr_nxt    = r_frm_ptr;
                        w_state_nxt = bus.eop_in ? IDLE : DROP;
                    end else begin
                        w_we     = 1'b1;
                        w_wr_nxt = r_wr_ptr + 1'b1;
                        if (bus.eop_in) begin
                            w_state_nxt = IDLE;
                            if (bus.error_in) begin
                                w_wr_nxt   = r_frm_ptr;
                                w_drop_add = 2'd1;
                            end else begin
                                w_cmt_nxt   = r_wr_ptr + 1'b1;
                                w_frame_inc = 1'b1;
                            end
                        end
                    end
                end
            end
            DROP: begin
                if (bus.in_valid && bus.eop_in) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_start) begin
            w_wr_nxt  = w_base;
            w_frm_nxt = w_base;
            if (w_full) begin
                w_overflow  = 1'b1;
                w_drop_add  = w_drop_add + 2'd1;
                w_state_nxt = bus.eop_in ? IDLE : DROP;
            end else begin
                w_we        = 1'b1;
                w_wr_nxt    = w_base + 1'b1;
                w_state_nxt = FRAME;
                if (bus.eop_in) begin
                    w_state_nxt = IDLE;
                    if (bus.error_in) begin
                        w_wr_nxt   = w_base;
                        w_drop_add = w_drop_add + 2'd1;
                    end else begin
                        w_cmt_nxt   = w_base + 1'b1;
                        w_frame_inc = 1'b1;
                    end
                end
            end
        end
    end

    assign w_frame_sum = {1'b0, r_frame_cnt} + {{CNT_W{1'b0}}, w_frame_inc};
    assign w_drop_sum  = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_add};
    assign w_load      = (r_rd_ptr != r_cmt_ptr) && (!r_out_valid || bus.out_ready);

    hdlc_buf_ram #(.AW(AW)) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_base[AW-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_frm_ptr   <= '0;
            r_cmt_ptr   <= '0;
            r_rd_ptr    <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_nxt;
            r_frm_ptr   <= w_frm_nxt;
            r_cmt_ptr   <= w_cmt_nxt;
            r_overflow  <= w_overflow;
            r_frame_cnt <= w_frame_sum[CNT_W] ? '1 : w_frame_sum[CNT_W-1:0];
            r_drop_cnt  <= w_drop_sum[CNT_W]  ? '1 : w_drop_sum[CNT_W-1:0];
            if (w_load) begin
                r_out       <= w_rdata;
                r_out_valid <= 1'b1;
                r_rd_ptr    <= r_rd_ptr + 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sop   = r_out.sop;
    assign bus.out_eop   = r_out.eop;
    assign bus.out_data  = r_out.data;
    assign bus.overflow  = r_overflow;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: doc/hdlc_frame_buffer.md
Name: hdlc_frame_buffer

Overview:
- Store-and-forward frame buffer directly downstream of the HDLC deframer (delineation -> byte_destuffing -> crc).
- Accepts destuffed, CRC-checked bytes with sop/eop/error markers; holds each frame until its eop; forwards only error-free frames over a valid/ready byte stream.
- Discards errored, aborted and overflowing frames entirely; counts good and dropped frames.

Parameters:
- AW, 8, address width; buffer depth = 2**AW bytes.
- CNT_W, 16, width of the saturating frame counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- in_valid  input  1  data_in/sop_in/eop_in/error_in qualify this cycle.
- sop_in  input  1  first byte of frame (from crc sop_out).
- eop_in  input  1  last byte of frame (from crc eop_out).
- error_in  input  1  CRC error for the frame; sampled only with eop_in.
- data_in  input  8  frame byte (from crc data_out).
- out_ready  input  1  downstream accepts the out_* byte.
- out_valid  output  1  out_* holds a byte of a committed frame.
- out_sop  output  1  out_data is the first byte of a frame.
- out_eop  output  1  out_data is the last byte of a frame.
- out_data  output  8  forwarded byte.
- overflow  output  1  one-cycle pulse when a frame is dropped for lack of space.
- frame_cnt  output  CNT_W  frames committed, saturating.
- drop_cnt  output  CNT_W  frames dropped (CRC error, abort, overflow), saturating.

Behaviour:
- Reset (rst=0, async): all pointers 0; state IDLE; out_valid/out_sop/out_eop/overflow=0; out_data=0; frame_cnt=drop_cnt=0. Memory contents are not reset.
- Storage: 2**AW x 10 bits, holding {sop,eop,data}.
- Pointers are AW+1 bits: wr_ptr, frm_ptr (start of the frame being written), cmt_ptr (end of committed data), rd_ptr.
- Full: wr_ptr - rd_ptr == 2**AW. Pointers wrap modulo 2**(AW+1).
- Write FSM:
  - IDLE: in_valid&sop_in -> write byte, frm_ptr<=wr_ptr, go to FRAME. Bytes without sop are ignored.
  - FRAME: each in_valid byte is written and wr_ptr increments.
    - eop_in&!error_in: write, cmt_ptr<=wr_ptr+1, frame_cnt++, go to IDLE.
    - eop_in&error_in: wr_ptr<=frm_ptr, drop_cnt++, go to IDLE.
  - DROP: bytes ignored until eop_in, then go to IDLE. No counter change at that eop.
- Single-byte frame (sop_in&eop_in in IDLE): handled as both start and end in one cycle; committed or dropped by error_in.
- sop_in while in FRAME (missing eop): current frame rewound (wr_ptr<=frm_ptr), drop_cnt++; the new byte then starts a fresh frame at the rewound position, same cycle.
- Full on an in_valid byte in FRAME: byte not written, wr_ptr<=frm_ptr, overflow=1 for one cycle, drop_cnt++.
  - If that byte carries eop: go to IDLE; otherwise go to DROP.
  - Full on a sop byte in IDLE: same, with no rewind needed.
- Frame larger than 2**AW bytes: always overflows; never deadlocks.
- Read side:
  - The out_* register loads mem[rd_ptr] and rd_ptr++ when rd_ptr != cmt_ptr and (!out_valid | out_ready).
  - Otherwise, out_valid clears on out_ready.
  - Sustains 1 byte/cycle with out_ready held high.
- out_* are stable while out_valid&!out_ready.
- Latency: eop_in presented in cycle t -> out_valid=1 with out_sop=1 for that frame in cycle t+2 (buffer previously empty, out_ready=1).
- Uncommitted bytes are never visible on out_*.
- Simultaneous read and write each cycle are permitted. Full uses rd_ptr, so the slot freed by a read in the same cycle is not usable until the next cycle.
- Counters saturate at all-ones. If commit and drop coincide via sop-abort, each counter updates independently.

Decomposition:
- Shared package hdlc_pkg: state encodings IDLE/FRAME/DROP, the entry layout (bit 9 sop, bit 8 eop, bits 7:0 data), and a default AW constant.
- One natural sub-module: hdlc_buf_ram, a 2**AW x 10 dual-port array (one write port, one async/registered-read port), so technology RAM can be substituted.
- Write FSM, pointers and output register remain in hdlc_frame_buffer.

Test Plan:
- Good frame: 5 bytes 0x11..0x15, eop with error_in=0, out_ready=1.
  - Response: out_valid in cycle t+2; out_data 0x11..0x15 on consecutive cycles; out_sop on 0x11, out_eop on 0x15; frame_cnt=1.
- CRC-error frame: 4 bytes with error_in=1 at eop, followed by a good 2-byte frame 0xA0,0xA1.
  - Response: only 0xA0,0xA1 emitted; frame_cnt=1, drop_cnt=1.
- Abort: sop 0x01,0x02, then sop 0x03,eop 0x04.
  - Response: output is exactly 0x03(sop),0x04(eop); drop_cnt=1.
- Overflow: AW=4, out_ready=0, write a 20-byte frame.
  - Response: overflow pulse on the 17th byte; no output; drop_cnt=1.
  - Then a 3-byte good frame is delivered intact.
- Backpressure: two back-to-back 3-byte frames; out_ready toggles 1,0,0,1...
  - Response: out_* held while stalled; 6 bytes delivered in order, with sop/eop flags correct.
- Reset mid-frame: assert rst=0 during byte 3 of a frame.
  - Response: out_valid=0 immediately and counters 0.
  - After release, a new 1-byte frame (sop&eop, 0x7E) is delivered with out_sop=out_eop=1.
